// File: rtl/analyzer_capture_sequencer_if.sv
// Register-bus port between the capture sequencer (master) and the
// analyzer register slave: write address/data/response, read address/data.
interface analyzer_capture_sequencer_if;
    logic [3:0]  M_WR_ADDR_ID;
    logic [31:0] M_WR_ADDR_ADDR;
    logic [7:0]  M_WR_ADDR_LEN;
    logic [1:0]  M_WR_ADDR_BURST;
    logic        M_WR_ADDR_VALID;
    logic        M_WR_ADDR_READY;

    logic [31:0] M_WR_DATA;
    logic [3:0]  M_WR_STRB;
    logic        M_WR_DATA_LAST;
    logic        M_WR_DATA_VALID;
    logic        M_WR_DATA_READY;

    logic [3:0]  M_WR_BACK_ID;
    logic [1:0]  M_WR_BACK_RESP;
    logic        M_WR_BACK_VALID;
    logic        M_WR_BACK_READY;

    logic [3:0]  M_RD_ADDR_ID;
    logic [31:0] M_RD_ADDR_ADDR;
    logic [7:0]  M_RD_ADDR_LEN;
    logic [1:0]  M_RD_ADDR_BURST;
    logic        M_RD_ADDR_VALID;
    logic        M_RD_ADDR_READY;

    logic [3:0]  M_RD_BACK_ID;
    logic [31:0] M_RD_DATA;
    logic [1:0]  M_RD_DATA_RESP;
    logic        M_RD_DATA_LAST;
    logic        M_RD_DATA_VALID;
    logic        M_RD_DATA_READY;

    modport master (
        output M_WR_ADDR_ID, M_WR_ADDR_ADDR, M_WR_ADDR_LEN,
        output M_WR_ADDR_BURST, M_WR_ADDR_VALID,
        input  M_WR_ADDR_READY,
        output M_WR_DATA, M_WR_STRB, M_WR_DATA_LAST, M_WR_DATA_VALID,
        input  M_WR_DATA_READY,
        input  M_WR_BACK_ID, M_WR_BACK_RESP, M_WR_BACK_VALID,
        output M_WR_BACK_READY,
        output M_RD_ADDR_ID, M_RD_ADDR_ADDR, M_RD_ADDR_LEN,
        output M_RD_ADDR_BURST, M_RD_ADDR_VALID,
        input  M_RD_ADDR_READY,
        input  M_RD_BACK_ID, M_RD_DATA, M_RD_DATA_RESP,
        input  M_RD_DATA_LAST, M_RD_DATA_VALID,
        output M_RD_DATA_READY
    );

    modport slave (
        input  M_WR_ADDR_ID, M_WR_ADDR_ADDR, M_WR_ADDR_LEN,
        input  M_WR_ADDR_BURST, M_WR_ADDR_VALID,
        output M_WR_ADDR_READY,
        input  M_WR_DATA, M_WR_STRB, M_WR_DATA_LAST, M_WR_DATA_VALID,
        output M_WR_DATA_READY,
        output M_WR_BACK_ID, M_WR_BACK_RESP, M_WR_BACK_VALID,
        input  M_WR_BACK_READY,
        input  M_RD_ADDR_ID, M_RD_ADDR_ADDR, M_RD_ADDR_LEN,
        input  M_RD_ADDR_BURST, M_RD_ADDR_VALID,
        output M_RD_ADDR_READY,
        output M_RD_BACK_ID, M_RD_DATA, M_RD_DATA_RESP,
        output M_RD_DATA_LAST, M_RD_DATA_VALID,
        input  M_RD_DATA_READY
    );
endinterface

// File: rtl/analyzer_capture_sequencer.sv
// Runs one analyzer capture over the register port: config writes,
// arm, poll for trigger, poll for capture done; optional abort/disarm.
module analyzer_capture_sequencer #(
    parameter int         POLL_GAP = 16,
    parameter logic [3:0] ID       = 4'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_load_num,
    input  logic [31:0] cfg_pre_load_num,
    input  logic [1:0]  cfg_trig_mode,
    input  logic [47:0] cfg_op,
    input  logic        cfg_force,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        aborted,
    output logic        trig_seen,
    analyzer_capture_sequencer_if.master m
);

    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [3:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_GAP,
        S_FIN,
        S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    widx_q, widx_d;
    logic [2:0]    beat_q, beat_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          phase_q, phase_d;
    logic          abort_q, abort_d;
    logic          disarm_q, disarm_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          aborted_q, aborted_d;
    logic          trig_q, trig_d;
    logic [31:0]   load_q, load_d;
    logic [31:0]   pre_q, pre_d;
    logic [1:0]    mode_q, mode_d;
    logic [47:0]   op_q, op_d;
    logic          force_q, force_d;

    logic [31:0]   w_addr;
    logic [31:0]   w_data;
    logic [2:0]    w_len;
    logic [3:0]    w_strb;
    logic          abort_req;
    logic          fin;

    // Field mux for the current write (config list or disarm)
    always_comb begin
        w_addr = '0;
        w_data = '0;
        w_len  = '0;
        w_strb = 4'hF;
        if (disarm_q) begin
            w_strb = 4'b0011;
        end else begin
            unique case (widx_q)
                3'd0: begin
                    w_addr = 32'h2;
                    w_data = load_q;
                end
                3'd1: begin
                    w_addr = 32'h3;
                    w_data = pre_q;
                end
                3'd2: begin
                    w_addr = 32'h1;
                    w_data = {30'd0, mode_q};
                end
                3'd3: begin
                    w_addr = 32'h10;
                    w_len  = 3'd7;
                    w_data = {26'd0, op_q[6*beat_q +: 6]};
                end
                default: begin
                    w_addr = 32'h0;
                    w_strb = 4'b0011;
                    w_data = force_q ? 32'h0000_0101 : 32'h0000_0001;
                end
            endcase
        end
    end

    assign abort_req = abort_q | (abort & busy_q);

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        phase_d   = phase_q;
        abort_d   = abort_q;
        disarm_d  = disarm_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        aborted_d = 1'b0;
        trig_d    = trig_q;
        load_d    = load_q;
        pre_d     = pre_q;
        mode_d    = mode_q;
        op_d      = op_q;
        force_d   = force_q;
        fin       = 1'b0;

        if (abort && busy_q) abort_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_d   = cfg_load_num;
                    pre_d    = cfg_pre_load_num;
                    mode_d   = cfg_trig_mode;
                    op_d     = cfg_op;
                    force_d  = cfg_force;
                    busy_d   = 1'b1;
                    trig_d   = 1'b0;
                    phase_d  = 1'b0;
                    widx_d   = '0;
                    beat_d   = '0;
                    abort_d  = 1'b0;
                    disarm_d = 1'b0;
                    state_d  = S_AW;
                end
            end
            S_AW: begin
                if (m.M_WR_ADDR_READY) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (m.M_WR_DATA_READY) begin
                    if (beat_q == w_len) state_d = S_B;
                    else beat_d = beat_q + 3'd1;
                end
            end
            S_B: begin
                if (m.M_WR_BACK_VALID) begin
                    if (disarm_q) begin
                        aborted_d = 1'b1;
                        busy_d    = 1'b0;
                        abort_d   = 1'b0;
                        disarm_d  = 1'b0;
                        state_d   = S_IDLE;
                    end else if (m.M_WR_BACK_RESP != 2'b00) begin
                        state_d = S_ERR;
                    end else if (abort_req) begin
                        disarm_d = 1'b1;
                        state_d  = S_AW;
                    end else if (widx_q == 3'd4) begin
                        state_d = S_AR;
                    end else begin
                        widx_d  = widx_q + 3'd1;
                        state_d = S_AW;
                    end
                end
            end
            S_AR: begin
                if (m.M_RD_ADDR_READY) state_d = S_R;
            end
            S_R: begin
                if (m.M_RD_DATA_VALID && m.M_RD_DATA_LAST) begin
                    if (m.M_RD_DATA_RESP != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        // A single status word may show trigger and done together
                        if (!phase_q) begin
                            if (!m.M_RD_DATA[0]) begin
                                trig_d  = 1'b1;
                                phase_d = 1'b1;
                                fin     = m.M_RD_DATA[24];
                            end
                        end else begin
                            fin = m.M_RD_DATA[24];
                        end
                        if (fin) begin
                            abort_d = 1'b0;
                            state_d = S_FIN;
                        end else if (abort_req) begin
                            disarm_d = 1'b1;
                            state_d  = S_AW;
                        end else if (POLL_GAP == 0) begin
                            state_d = S_AR;
                        end else begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (abort_req) begin
                    disarm_d = 1'b1;
                    state_d  = S_AW;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_AR;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            widx_q    <= '0;
            beat_q    <= '0;
            gap_q     <= '0;
            phase_q   <= 1'b0;
            abort_q   <= 1'b0;
            disarm_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            trig_q    <= 1'b0;
            load_q    <= '0;
            pre_q     <= '0;
            mode_q    <= '0;
            op_q      <= '0;
            force_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            beat_q    <= beat_d;
            gap_q     <= gap_d;
            phase_q   <= phase_d;
            abort_q   <= abort_d;
            disarm_q  <= disarm_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            aborted_q <= aborted_d;
            trig_q    <= trig_d;
            load_q    <= load_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            op_q      <= op_d;
            force_q   <= force_d;
        end
    end

    // Bus outputs decode from registered state only, so reset clears them at once
    assign m.M_WR_ADDR_ID    = ID;
    assign m.M_WR_ADDR_ADDR  = w_addr;
    assign m.M_WR_ADDR_LEN   = {5'd0, w_len};
    assign m.M_WR_ADDR_BURST = 2'b01;
    assign m.M_WR_ADDR_VALID = (state_q == S_AW);

    assign m.M_WR_DATA       = w_data;
    assign m.M_WR_STRB       = w_strb;
    assign m.M_WR_DATA_LAST  = (beat_q == w_len);
    assign m.M_WR_DATA_VALID = (state_q == S_W);
    assign m.M_WR_BACK_READY = (state_q == S_B);

    assign m.M_RD_ADDR_ID    = ID;
    assign m.M_RD_ADDR_ADDR  = 32'h0;
    assign m.M_RD_ADDR_LEN   = 8'd0;
    assign m.M_RD_ADDR_BURST = 2'b01;
    assign m.M_RD_ADDR_VALID = (state_q == S_AR);
    assign m.M_RD_DATA_READY = (state_q == S_R);

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign aborted   = aborted_q;
    assign trig_seen = trig_q;

    logic unused_bus;
    assign unused_bus = ^{m.M_WR_BACK_ID, m.M_RD_BACK_ID,
                          m.M_RD_DATA[31:25], m.M_RD_DATA[23:1]};

endmodule
